// File: rtl/mips_mem_arbiter_if.sv
// Fetch and load/store request/ready bundle between the MIPS32 core and the shared memory.
// The core drives master; the arbiter takes slave.
interface mips_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_ready;
    logic [DATA_W-1:0]     i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_ready;
    logic [DATA_W-1:0]     d_rdata;
    logic                  busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  i_ready, i_rdata, d_ready, d_rdata, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output i_ready, i_rdata, d_ready, d_rdata, busy
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Shared fetch/data RAM, round-robin arbitrated; ready pulses WAIT_STATES+2 cycles after grant.
// Requests are held until ready (one op in flight); MEM_BYTE_EN enables byte-masked stores.
module mips_mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    mips_mem_arbiter_if.slave bus
);
    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam int         NB = DATA_W / 8;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              gnt_d, gnt_d_nxt;
    logic              last_d, last_d_nxt;
    logic              take;
    logic              ram_op;
    logic [AW-1:0]     sel_idx;
    logic [AW-1:0]     lat_idx;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte offset and bits above the RAM depth are dropped, so addresses wrap.
    assign sel_idx = gnt_d_nxt ? bus.d_addr[AW+1:2] : bus.i_addr[AW+1:2];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        gnt_d_nxt  = gnt_d;
        last_d_nxt = last_d;
        take       = 1'b0;
        ram_op     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    take      = 1'b1;
                    // On a tie, the port that did not win last time gets the slot.
                    gnt_d_nxt = bus.d_req && (!bus.i_req || !last_d);
                    cnt_nxt   = 4'd0;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == WS) begin
                    ram_op    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                last_d_nxt = gnt_d;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            gnt_d     <= 1'b0;
            last_d    <= 1'b0;
            lat_idx   <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gnt_d  <= gnt_d_nxt;
            last_d <= last_d_nxt;
            if (take) begin
                lat_idx   <= sel_idx;
                lat_we    <= gnt_d_nxt & bus.d_we;
                lat_wdata <= bus.d_wdata;
            end
            if (ram_op && !lat_we) begin
                if (gnt_d) d_rdata_q <= mem[lat_idx];
                else       i_rdata_q <= mem[lat_idx];
            end
        end
    end

`ifdef MEM_BYTE_EN
    logic [NB-1:0] lat_be;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     lat_be <= '0;
        else if (take) lat_be <= bus.d_be;
    end

    always_ff @(posedge clk) begin
        if (ram_op && lat_we) begin
            for (int k = 0; k < NB; k++) begin
                if (lat_be[k]) mem[lat_idx][8*k +: 8] <= lat_wdata[8*k +: 8];
            end
        end
    end

    logic unused_addr;
    assign unused_addr = ^{bus.i_addr[ADDR_W-1:AW+2], bus.i_addr[1:0],
                           bus.d_addr[ADDR_W-1:AW+2], bus.d_addr[1:0]};
`else
    // RAM is never reset: an op aborted by reset has no commit edge.
    always_ff @(posedge clk) begin
        if (ram_op && lat_we) mem[lat_idx] <= lat_wdata;
    end

    logic unused_addr;
    assign unused_addr = ^{bus.i_addr[ADDR_W-1:AW+2], bus.i_addr[1:0],
                           bus.d_addr[ADDR_W-1:AW+2], bus.d_addr[1:0], bus.d_be};
`endif

    assign bus.i_ready = (state == DONE) && !gnt_d;
    assign bus.d_ready = (state == DONE) && gnt_d;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Three arbiters (WAIT_STATES 1, 0, 3) driven through a scoreboard and a reference word model.
module tb_mips_mem_arbiter;
    logic clk;
    logic        rst     [3];
    logic        i_req   [3];
    logic [31:0] i_addr  [3];
    logic        d_req   [3];
    logic        d_we    [3];
    logic [31:0] d_addr  [3];
    logic [31:0] d_wdata [3];
    logic [3:0]  d_be    [3];
    logic        i_rdy   [3];
    logic [31:0] i_rd    [3];
    logic        d_rdy   [3];
    logic [31:0] d_rd    [3];
    logic        busy_a  [3];

    typedef struct {
        int          u;
        bit          port_d;
        bit          load;
        logic [31:0] data;
    } sb_t;

    sb_t         sb [$];
    sb_t         mon_e;
    logic [31:0] model [3][256];
    int          n_cmp = 0;
    int          n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_unit
        localparam int WSG = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        mips_mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();
        assign bus.i_req   = i_req[g];
        assign bus.i_addr  = i_addr[g];
        assign bus.d_req   = d_req[g];
        assign bus.d_we    = d_we[g];
        assign bus.d_addr  = d_addr[g];
        assign bus.d_wdata = d_wdata[g];
        assign bus.d_be    = d_be[g];
        assign i_rdy[g]    = bus.i_ready;
        assign i_rd[g]     = bus.i_rdata;
        assign d_rdy[g]    = bus.d_ready;
        assign d_rd[g]     = bus.d_rdata;
        assign busy_a[g]   = bus.busy;
        mips_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(WSG)) dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus)
        );
    end

    function automatic int ws_of(input int u);
        return (u == 0) ? 1 : (u == 1) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (i_rdy[u] || d_rdy[u]) begin
                check("ready_excl", {31'b0, i_rdy[u] & d_rdy[u]}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'(u), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_unit", 32'(u), 32'(mon_e.u));
                    check("sb_port", {31'b0, d_rdy[u]}, {31'b0, mon_e.port_d});
                    if (mon_e.load)
                        check("sb_rdata", d_rdy[u] ? d_rd[u] : i_rd[u], mon_e.data);
                end
            end
        end
    end

    task automatic op(input int u, input bit pd, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input bit scramble);
        sb_t        e;
        int         n;
        bit         seen;
        logic [7:0] idx;
        idx      = addr[9:2];
        e.u      = u;
        e.port_d = pd;
        e.load   = !we;
        e.data   = model[u][idx];
        if (we) begin
`ifdef MEM_BYTE_EN
            for (int k = 0; k < 4; k++)
                if (be[k]) model[u][idx][8*k +: 8] = wd[8*k +: 8];
`else
            model[u][idx] = wd;
`endif
        end
        sb.push_back(e);
        if (pd) begin
            d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = addr; d_wdata[u] = wd; d_be[u] = be;
        end else begin
            i_req[u] = 1'b1; i_addr[u] = addr;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            check("busy_in_op", {31'b0, busy_a[u]}, 32'd1);
            if (scramble && n == 1) begin
                i_addr[u] = ~addr; d_addr[u] = ~addr; d_wdata[u] = ~wd; d_we[u] = ~we;
                i_req[u] = 1'b0; d_req[u] = 1'b0;
            end
            seen = pd ? d_rdy[u] : i_rdy[u];
        end
        check("latency", 32'(n), 32'(ws_of(u) + 2));
        i_req[u] = 1'b0;
        d_req[u] = 1'b0;
        @(negedge clk);
        check("busy_idle", {31'b0, busy_a[u]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, last, first, cyc;
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; i_req[u] = 1'b0; i_addr[u] = '0; d_req[u] = 1'b0; d_we[u] = 1'b0;
            d_addr[u] = '0; d_wdata[u] = '0; d_be[u] = 4'hF;
        end
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_i_ready", {31'b0, i_rdy[u]}, 32'd0);
            check("rst_d_ready", {31'b0, d_rdy[u]}, 32'd0);
            check("rst_i_rdata", i_rd[u], 32'd0);
            check("rst_d_rdata", d_rd[u], 32'd0);
            check("rst_busy", {31'b0, busy_a[u]}, 32'd0);
        end
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        @(negedge clk);

        // Store then fetch on WS=1, plus wrap and byte-offset aliasing.
        op(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        op(0, 0, 0, 32'h10, 32'h0, 4'hF, 0);
        op(0, 1, 1, 32'h400, 32'h11, 4'hF, 0);
        op(0, 1, 0, 32'h0, 32'h0, 4'hF, 0);
        op(0, 0, 0, 32'h13, 32'h0, 4'hF, 0);
        op(0, 1, 0, 32'h13, 32'h0, 4'hF, 1);

        // Byte-enable store (full-word store when the feature is off).
        op(0, 1, 1, 32'h30, 32'hAABBCCDD, 4'hF, 0);
        op(0, 1, 1, 32'h30, 32'h11223344, 4'b0101, 0);
        op(0, 1, 0, 32'h30, 32'h0, 4'hF, 0);
        op(0, 0, 0, 32'h30, 32'h0, 4'hF, 0);

        // Both ports requesting from reset: D, I, D, I, each WS+3 cycles apart.
        rst[0] = 1'b1;
        i_req[0] = 1'b1; i_addr[0] = 32'h10;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            mon_e.u = 0; mon_e.port_d = (k % 2 == 0); mon_e.load = 1'b1;
            mon_e.data = (k % 2 == 0) ? model[0][0] : model[0][4];
            sb.push_back(mon_e);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        got = 0; last = -1; first = -1; cyc = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (i_rdy[0] || d_rdy[0]) begin
                if (last >= 0) check("rr_spacing", 32'(cyc - last), 32'd4);
                else first = cyc;
                last = cyc;
                got++;
            end
        end
        check("rr_count", 32'(got), 32'd4);
        check("rr_first_lat", 32'(first), 32'd3);
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // WS=0 and WS=3 latency, with a request changed/dropped after grant.
        op(1, 1, 1, 32'h44, 32'h0BADF00D, 4'hF, 0);
        op(1, 1, 0, 32'h44, 32'h0, 4'hF, 0);
        op(1, 0, 0, 32'h44, 32'h0, 4'hF, 1);
        op(2, 1, 1, 32'h20, 32'h12345678, 4'hF, 0);
        op(2, 0, 0, 32'h20, 32'h0, 4'hF, 0);
        op(2, 1, 1, 32'h24, 32'h55AA55AA, 4'hF, 1);
        op(2, 1, 0, 32'h24, 32'h0, 4'hF, 0);

        // Reset in ACCESS (cnt=1) of a WS=3 store: no ready, word unchanged.
        d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 32'h20; d_wdata[2] = 32'hCAFE0000;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'b0, busy_a[2]}, 32'd1);
        rst[2] = 1'b1;
        d_req[2] = 1'b0;
        #1;
        check("abort_busy_after", {31'b0, busy_a[2]}, 32'd0);
        check("abort_d_ready", {31'b0, d_rdy[2]}, 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        @(negedge clk);
        op(2, 1, 0, 32'h20, 32'h0, 4'hF, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
